incr_result_scoreboard: RTL and testbench
=========================================

# incr_result_scoreboard

Downstream checking stage for the increment sub-block, which returns `narrow+1` as a 32-bit word and `quad+1` as a 64-bit word. It captures every stimulus pair sent to the sub-block in a small in-order queue. It then compares each returned result against the value it computes itself, and keeps pass/fail statistics plus a sticky failure state. This lets regression tests self-check streams of back-to-back transactions instead of a single cycle-2 check.

## Interface
- `DEPTH`, 4: expected-value queue entries (≥2, power of two).
- `CNT_W`, 16: width of the counters and of the transaction index.
- `clk` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `stim_valid` input 1: stimulus pair offered.
- `stim_ready` output 1: queue can accept; equals `occupancy != DEPTH`.
- `stim_narrow` input 8: narrow operand sent to the sub-block.
- `stim_quad` input 64: quad operand sent to the sub-block.
- `res_valid` input 1: sub-block result present this cycle.
- `res_longout` input 32: returned long result.
- `res_quadout` input 64: returned quad result.
- `occupancy` output $clog2(DEPTH+1): entries currently queued.
- `pass_count` output CNT_W: matched results.
- `fail_count` output CNT_W: mismatched plus orphan results.
- `orphan` output 1: sticky; set when a result arrives with an empty queue.
- `fail_seen` output 1: sticky; set on the first mismatch or orphan.
- `first_fail_index` output CNT_W: 0-based result index of the first failure.
- `idle` output 1: `occupancy==0` and state is not FAILED.

## Operation
- **Push:** `stim_valid && stim_ready`.
  - Stores `{stim_narrow, stim_quad}` at the tail.
  - No push while full, even if a pop happens in the same cycle.
- **Pop:** `res_valid` with a non-empty queue. The head entry is compared combinationally:
  - `exp_long = {24'b0, narrow} + 32'd1`. No 8-bit wrap, so 8'hFF gives 32'h100.
  - `exp_quad = quad + 64'd1`, modulo 2^64, so all-ones gives 0.
  - Match requires both fields equal.
- **Orphan:** `res_valid` with an empty queue.
  - Counts as a failure and sets `orphan`.
  - Queue is unchanged.
  - A push in the same cycle does not bypass to the comparator; the push still occurs.
- **Result index:** incremented on every `res_valid`, orphans included.
- **Counters:** saturate at all-ones and never wrap.
- **State machine:** states IDLE, ACTIVE, FAILED.
  - IDLE → ACTIVE on the first push.
  - ACTIVE → IDLE when `occupancy` returns to 0 with no failure.
  - Any state → FAILED on a mismatch or orphan. FAILED is sticky until `reset`.
  - In FAILED, pushes, pops and counting continue; only `first_fail_index` is frozen.
- **Simultaneous push and pop:** when not empty and not full, `occupancy` is unchanged; queue order is preserved.

## Timing
- Reset values:
  - `occupancy`, `pass_count`, `fail_count`, `first_fail_index` = 0.
  - `orphan`, `fail_seen` = 0.
  - `stim_ready` = 1, `idle` = 1.
  - State = IDLE. Queue pointers are cleared; entry contents are don't-care.
- Push-to-compare latency:
  - An entry pushed at edge N can be compared by a result presented in cycle N+1.
  - A result in the same cycle as the push sees the pre-push queue.
- Compare-to-status latency: counters, `fail_seen`, `orphan`, `first_fail_index` and `occupancy` are updated at the edge ending the result cycle (1 cycle).
- `stim_ready` is combinational from registered `occupancy` only. It has no path from `stim_valid` or `res_valid`.
- Reset asserted mid-stream:
  - Flushes the queue and clears all statistics at that edge.
  - Inputs in the reset cycle are ignored.

## Structure
- Package `incr_sb_pkg` holds:
  - the state enum `sb_state_e` (IDLE/ACTIVE/FAILED);
  - the entry struct `sb_entry_t` {narrow[7:0], quad[63:0]};
  - functions `exp_long(narrow)` and `exp_quad(quad)`.
- Sub-module `incr_sb_fifo` (parameter DEPTH):
  - synchronous FIFO of `sb_entry_t` with push/pop/full/empty/count;
  - pointer wrap modulo DEPTH.
- Top level holds the comparator, counters, index register and FSM.

## Test plan
- **Single match:** push narrow 8'h78, quad 64'h12345678_abcdef12; next cycle present 32'h79 and 64'h12345678_abcdef13 → pass_count=1, fail_count=0, idle=1.
- **Boundary values:** push narrow 8'hFF and quad all-ones; present 32'h100 and 64'h0 → pass. Separately, present 32'h0 for the same narrow → fail_seen=1, first_fail_index=0.
- **Full and wrap-around:**
  - Push 4 entries with no results → stim_ready=0 and occupancy=4; a 5th offer is not accepted.
  - Then 4 matching results → pass_count=4.
  - Then 8 more push/result pairs, overlapped at one per cycle → pass_count=12, order preserved.
- **Orphan:** res_valid while the queue is empty and a push occurs in the same cycle → orphan=1, fail_count=1, occupancy=1. The next correct result passes, and first_fail_index stays 0.
- **Reset mid-stream:** 3 entries queued and pass_count=5, assert reset for 1 cycle → all outputs return to their reset values, and the next result is flagged as an orphan.

Source files
------------

// File: rtl/incr_sb_pkg.sv
// Shared types and expected-value helpers for the increment result scoreboard.
package incr_sb_pkg;

   typedef enum logic [1:0] {
      SB_IDLE,
      SB_ACTIVE,
      SB_FAILED
   } sb_state_e;

   typedef struct packed {
      logic [7:0]  narrow;
      logic [63:0] quad;
   } sb_entry_t;

   // Widen before adding so 8'hFF yields 32'h100 rather than wrapping.
   function automatic logic [31:0] exp_long(input logic [7:0] narrow);
      return {24'b0, narrow} + 32'd1;
   endfunction

   function automatic logic [63:0] exp_quad(input logic [63:0] quad);
      return quad + 64'd1;
   endfunction

endpackage

// File: rtl/incr_sb_fifo.sv
// In-order queue of expected-value entries; pointers wrap modulo DEPTH.
module incr_sb_fifo
   import incr_sb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  sb_entry_t                    wdata,
   output sb_entry_t                    rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   sb_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry contents need no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/incr_result_scoreboard.sv
// Checks increment sub-block results against queued stimulus; keeps pass/fail
// statistics, a sticky failure state and the index of the first failure.
module incr_result_scoreboard
   import incr_sb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stim_valid,
   output logic                         stim_ready,
   input  logic [7:0]                   stim_narrow,
   input  logic [63:0]                  stim_quad,
   input  logic                         res_valid,
   input  logic [31:0]                  res_longout,
   input  logic [63:0]                  res_quadout,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             pass_count,
   output logic [CNT_W-1:0]             fail_count,
   output logic                         orphan,
   output logic                         fail_seen,
   output logic [CNT_W-1:0]             first_fail_index,
   output logic                         idle
);

   localparam int OW = $clog2(DEPTH+1);

   sb_state_e         state_q, state_d;
   sb_entry_t         head;
   logic              push, pop, full, empty;
   logic              res_orphan, res_match, res_fail;
   logic [OW-1:0]     occ_next;
   logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
   logic [CNT_W-1:0]  idx_q, idx_d, ffi_q, ffi_d;
   logic              orphan_q, orphan_d, fail_seen_q, fail_seen_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign stim_ready = (occupancy != OW'(DEPTH));
   assign push       = stim_valid && stim_ready;
   assign pop        = res_valid && !empty;

   incr_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata ({stim_narrow, stim_quad}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (occupancy)
   );

   always_comb begin
      res_orphan  = res_valid && empty;
      res_match   = (exp_long(head.narrow) == res_longout) &&
                    (exp_quad(head.quad) == res_quadout);
      res_fail    = res_orphan || (pop && !res_match);

      pass_d      = pass_q;
      fail_d      = fail_q;
      idx_d       = idx_q;
      ffi_d       = ffi_q;
      orphan_d    = orphan_q || res_orphan;
      fail_seen_d = fail_seen_q || res_fail;
      if (pop && res_match) pass_d = sat_inc(pass_q);
      if (res_fail)         fail_d = sat_inc(fail_q);
      if (res_valid)        idx_d  = sat_inc(idx_q);
      if (res_fail && !fail_seen_q) ffi_d = idx_q;

      occ_next = occupancy;
      case ({push, pop})
         2'b10:   occ_next = occupancy + OW'(1);
         2'b01:   occ_next = occupancy - OW'(1);
         default: occ_next = occupancy;
      endcase

      state_d = state_q;
      case (state_q)
         SB_IDLE:   if (push) state_d = SB_ACTIVE;
         SB_ACTIVE: if (occ_next == '0) state_d = SB_IDLE;
         default:   state_d = state_q;
      endcase
      if (res_fail) state_d = SB_FAILED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SB_IDLE;
         pass_q      <= '0;
         fail_q      <= '0;
         idx_q       <= '0;
         ffi_q       <= '0;
         orphan_q    <= 1'b0;
         fail_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         idx_q       <= idx_d;
         ffi_q       <= ffi_d;
         orphan_q    <= orphan_d;
         fail_seen_q <= fail_seen_d;
      end
   end

   assign pass_count       = pass_q;
   assign fail_count       = fail_q;
   assign orphan           = orphan_q;
   assign fail_seen        = fail_seen_q;
   assign first_fail_index = ffi_q;
   assign idle             = (occupancy == '0) && (state_q != SB_FAILED);

endmodule

// File: tb/tb_incr_result_scoreboard.sv
// Directed bench for incr_result_scoreboard with a queue-based reference model
// checked every cycle plus literal expectations at key points.
module tb_incr_result_scoreboard;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        stim_valid, stim_ready;
   logic [7:0]  stim_narrow;
   logic [63:0] stim_quad;
   logic        res_valid;
   logic [31:0] res_longout;
   logic [63:0] res_quadout;
   logic [2:0]  occupancy;
   logic [CNT_W-1:0] pass_count, fail_count, first_fail_index;
   logic        orphan, fail_seen, idle;

   int total = 0;
   int bad   = 0;

   incr_result_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .stim_valid       (stim_valid),
      .stim_ready       (stim_ready),
      .stim_narrow      (stim_narrow),
      .stim_quad        (stim_quad),
      .res_valid        (res_valid),
      .res_longout      (res_longout),
      .res_quadout      (res_quadout),
      .occupancy        (occupancy),
      .pass_count       (pass_count),
      .fail_count       (fail_count),
      .orphan           (orphan),
      .fail_seen        (fail_seen),
      .first_fail_index (first_fail_index),
      .idle             (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queue of {narrow, quad} and integer statistics.
   logic [71:0] mq[$];
   int          m_pass, m_fail, m_idx, m_ffi;
   bit          m_orphan, m_fail_seen, started;

   always @(posedge clk) begin
      logic [71:0] e;
      bit          can_push;
      if (reset) begin
         mq.delete();
         m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 0;
         m_orphan = 0; m_fail_seen = 0;
         started = 1;
      end else begin
         can_push = stim_valid && (mq.size() < DEPTH);
         if (res_valid) begin
            bit failed;
            if (mq.size() == 0) begin
               failed   = 1;
               m_orphan = 1;
            end else begin
               e = mq.pop_front();
               failed = !((res_longout == {24'b0, e[71:64]} + 32'd1) &&
                          (res_quadout == e[63:0] + 64'd1));
               if (!failed && m_pass < 65535) m_pass++;
            end
            if (failed) begin
               if (m_fail < 65535) m_fail++;
               if (!m_fail_seen) m_ffi = m_idx;
               m_fail_seen = 1;
            end
            if (m_idx < 65535) m_idx++;
         end
         if (can_push) mq.push_back({stim_narrow, stim_quad});
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_ready",  stim_ready, 64'(mq.size() != DEPTH));
         chk("m_occ",    occupancy, 64'(mq.size()));
         chk("m_pass",   pass_count, 64'(m_pass));
         chk("m_fail",   fail_count, 64'(m_fail));
         chk("m_orphan", orphan, 64'(m_orphan));
         chk("m_fseen",  fail_seen, 64'(m_fail_seen));
         chk("m_ffi",    first_fail_index, 64'(m_ffi));
         chk("m_idle",   idle, 64'(mq.size() == 0 && !m_fail_seen));
      end
   end

   task automatic step(input logic sv, input logic [7:0] n, input logic [63:0] q,
                       input logic rv, input logic [31:0] lo, input logic [63:0] qo);
      stim_valid = sv; stim_narrow = n; stim_quad = q;
      res_valid = rv; res_longout = lo; res_quadout = qo;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc();
      step(0, 8'h0, 64'h0, 0, 32'h0, 64'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_cyc();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] ent_n(input int i);
      return 8'(8'hF0 + i * 8'd3);
   endfunction

   function automatic logic [63:0] ent_q(input int i);
      return 64'hFFFF_FFFF_FFFF_FFFD + 64'(i) * 64'h0000_0001_0000_0001;
   endfunction

   initial begin
      reset = 1'b1;
      stim_valid = 0; stim_narrow = 0; stim_quad = 0;
      res_valid = 0; res_longout = 0; res_quadout = 0;
      idle_cyc();
      idle_cyc();
      reset = 1'b0;
      chk("rst_occ",   occupancy, 64'd0);
      chk("rst_ready", stim_ready, 64'd1);
      chk("rst_idle",  idle, 64'd1);
      chk("rst_pass",  pass_count, 64'd0);

      // Single match
      step(1, 8'h78, 64'h12345678_abcdef12, 0, 32'h0, 64'h0);
      chk("single_busy", idle, 64'd0);
      step(0, 8'h0, 64'h0, 1, 32'h79, 64'h12345678_abcdef13);
      chk("single_pass", pass_count, 64'd1);
      chk("single_fail", fail_count, 64'd0);
      chk("single_idle", idle, 64'd1);

      // Boundary pass
      do_reset();
      step(1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0, 64'h0);
      step(0, 8'h0, 64'h0, 1, 32'h100, 64'h0);
      chk("bnd_pass", pass_count, 64'd1);
      chk("bnd_fseen0", fail_seen, 64'd0);

      // Boundary fail: 8-bit wrap value must be rejected
      do_reset();
      step(1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0, 64'h0);
      step(0, 8'h0, 64'h0, 1, 32'h0, 64'h0);
      chk("bnd_fseen", fail_seen, 64'd1);
      chk("bnd_ffi",   first_fail_index, 64'd0);
      chk("bnd_fcnt",  fail_count, 64'd1);
      chk("bnd_idle",  idle, 64'd0);

      // Full, rejected 5th offer, drain, then overlapped stream
      do_reset();
      for (int i = 0; i < 4; i++) step(1, ent_n(i), ent_q(i), 0, 32'h0, 64'h0);
      chk("full_ready", stim_ready, 64'd0);
      chk("full_occ",   occupancy, 64'd4);
      step(1, 8'h55, 64'h55, 0, 32'h0, 64'h0);
      chk("full_occ5",  occupancy, 64'd4);
      for (int i = 0; i < 4; i++)
         step(0, 8'h0, 64'h0, 1, {24'b0, ent_n(i)} + 32'd1, ent_q(i) + 64'd1);
      chk("drain_pass", pass_count, 64'd4);
      for (int k = 0; k <= 8; k++)
         step(k < 8, ent_n(k + 4), ent_q(k + 4), k > 0,
              {24'b0, ent_n(k + 3)} + 32'd1, ent_q(k + 3) + 64'd1);
      chk("wrap_pass", pass_count, 64'd12);
      chk("wrap_fail", fail_count, 64'd0);
      chk("wrap_idle", idle, 64'd1);

      // Orphan with same-cycle push
      do_reset();
      step(1, 8'h20, 64'h0000_0000_0000_0099, 1, 32'h21, 64'h9A);
      chk("orph_flag", orphan, 64'd1);
      chk("orph_fcnt", fail_count, 64'd1);
      chk("orph_occ",  occupancy, 64'd1);
      step(0, 8'h0, 64'h0, 1, 32'h21, 64'h9A);
      chk("orph_pass", pass_count, 64'd1);
      chk("orph_ffi",  first_fail_index, 64'd0);
      step(1, 8'h30, 64'h5, 0, 32'h0, 64'h0);
      step(0, 8'h0, 64'h0, 1, 32'h31, 64'h7);
      chk("orph_ffi2", first_fail_index, 64'd0);
      chk("orph_fc2",  fail_count, 64'd2);

      // Reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1, ent_n(i), ent_q(i), 0, 32'h0, 64'h0);
         step(0, 8'h0, 64'h0, 1, {24'b0, ent_n(i)} + 32'd1, ent_q(i) + 64'd1);
      end
      for (int i = 0; i < 3; i++) step(1, ent_n(i), ent_q(i), 0, 32'h0, 64'h0);
      chk("mid_pass", pass_count, 64'd5);
      chk("mid_occ",  occupancy, 64'd3);
      reset = 1'b1;
      step(1, 8'h1, 64'h1, 1, 32'h2, 64'h2);
      reset = 1'b0;
      chk("mrst_occ",   occupancy, 64'd0);
      chk("mrst_pass",  pass_count, 64'd0);
      chk("mrst_fail",  fail_count, 64'd0);
      chk("mrst_ffi",   first_fail_index, 64'd0);
      chk("mrst_orph",  orphan, 64'd0);
      chk("mrst_fseen", fail_seen, 64'd0);
      chk("mrst_ready", stim_ready, 64'd1);
      chk("mrst_idle",  idle, 64'd1);
      step(0, 8'h0, 64'h0, 1, {24'b0, ent_n(0)} + 32'd1, ent_q(0) + 64'd1);
      chk("mrst_orphan", orphan, 64'd1);
      chk("mrst_fcnt",   fail_count, 64'd1);
      idle_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
